// File: rtl/stopwatch_counter_if.sv
// Control and BCD display bundle between the stopwatch core and its neighbours
// (tick dividers, button debouncers, seven-segment multiplexer).
interface stopwatch_counter_if;
  localparam int unsigned DW = 4;

  logic          tick_1hz;
  logic          tick_2hz;
  logic          pause_btn;
  logic          clr;
  logic          adj;
  logic          sel;
  logic [DW-1:0] sec_1;
  logic [DW-1:0] sec_2;
  logic [DW-1:0] min_1;
  logic [DW-1:0] min_2;
  logic          blink_min;
  logic          blink_sec;
  logic          paused;

  modport master (
    output tick_1hz, tick_2hz, pause_btn, clr, adj, sel,
    input  sec_1, sec_2, min_1, min_2, blink_min, blink_sec, paused
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_btn, clr, adj, sel,
    output sec_1, sec_2, min_1, min_2, blink_min, blink_sec, paused
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core with pause toggle and per-field adjust.
// All outputs come straight from flops.
module stopwatch_counter #(
  parameter int unsigned MIN_LIMIT = 59
) (
  input logic                clk,
  input logic                rst_n,
  stopwatch_counter_if.slave bus
);
  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] D0    = '0;
  localparam logic [DW-1:0] D1    = DW'(1);
  localparam logic [DW-1:0] D5    = DW'(5);
  localparam logic [DW-1:0] D9    = DW'(9);
  localparam logic [DW-1:0] LIM_2 = DW'(MIN_LIMIT / 10);
  localparam logic [DW-1:0] LIM_1 = DW'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] sec_1_q, sec_1_d;
  logic [DW-1:0] sec_2_q, sec_2_d;
  logic [DW-1:0] min_1_q, min_1_d;
  logic [DW-1:0] min_2_q, min_2_d;
  logic          pause_q, pause_d;
  logic          pe_q, pe_d;
  logic          flag_q, flag_d;
  logic          blink_min_q, blink_min_d;
  logic          blink_sec_q, blink_sec_d;

  logic [DW-1:0] s1_inc, s2_inc, m1_inc, m2_inc;
  logic          sec_carry, min_at_lim;

  // Incremented field values; seconds wrap 59->00, minutes wrap MIN_LIMIT->00
  always_comb begin
    sec_carry  = (sec_2_q == D5) && (sec_1_q == D9);
    min_at_lim = (min_2_q == LIM_2) && (min_1_q == LIM_1);
    s1_inc     = (sec_1_q == D9) ? D0 : sec_1_q + D1;
    s2_inc     = sec_2_q;
    if (sec_1_q == D9) begin
      s2_inc = (sec_2_q == D5) ? D0 : sec_2_q + D1;
    end
    m1_inc = (min_1_q == D9) ? D0 : min_1_q + D1;
    m2_inc = (min_1_q == D9) ? min_2_q + D1 : min_2_q;
    if (min_at_lim) begin
      m1_inc = D0;
      m2_inc = D0;
    end
  end

  // Digit update: clear beats adjust beats counting
  always_comb begin
    sec_1_d = sec_1_q;
    sec_2_d = sec_2_q;
    min_1_d = min_1_q;
    min_2_d = min_2_q;
    if (bus.clr) begin
      sec_1_d = D0;
      sec_2_d = D0;
      min_1_d = D0;
      min_2_d = D0;
    end else if ((state_q == ST_ADJUST) && bus.tick_2hz) begin
      if (bus.sel) begin
        sec_1_d = sec_carry ? D0 : s1_inc;
        sec_2_d = sec_carry ? D0 : s2_inc;
      end else begin
        min_1_d = m1_inc;
        min_2_d = m2_inc;
      end
    end else if ((state_q == ST_RUN) && bus.tick_1hz) begin
      sec_1_d = s1_inc;
      sec_2_d = s2_inc;
      if (sec_carry) begin
        min_1_d = m1_inc;
        min_2_d = m2_inc;
      end
    end
  end

  // Pause edge is registered, so the flag toggles one edge after it is detected
  always_comb begin
    pause_d     = bus.pause_btn;
    pe_d        = bus.pause_btn & ~pause_q;
    flag_d      = flag_q ^ pe_q;
    blink_min_d = bus.adj & ~bus.sel;
    blink_sec_d = bus.adj & bus.sel;
    state_d     = ST_RUN;
    if (bus.adj) begin
      state_d = ST_ADJUST;
    end else if (flag_d) begin
      state_d = ST_PAUSED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sec_1_q     <= D0;
      sec_2_q     <= D0;
      min_1_q     <= D0;
      min_2_q     <= D0;
      pause_q     <= 1'b0;
      pe_q        <= 1'b0;
      flag_q      <= 1'b0;
      blink_min_q <= 1'b0;
      blink_sec_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_1_q     <= sec_1_d;
      sec_2_q     <= sec_2_d;
      min_1_q     <= min_1_d;
      min_2_q     <= min_2_d;
      pause_q     <= pause_d;
      pe_q        <= pe_d;
      flag_q      <= flag_d;
      blink_min_q <= blink_min_d;
      blink_sec_q <= blink_sec_d;
    end
  end

  assign bus.sec_1     = sec_1_q;
  assign bus.sec_2     = sec_2_q;
  assign bus.min_1     = min_1_q;
  assign bus.min_2     = min_2_q;
  assign bus.blink_min = blink_min_q;
  assign bus.blink_sec = blink_sec_q;
  assign bus.paused    = flag_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random stimulus against
// a seconds-arithmetic reference model, on MIN_LIMIT=59 and MIN_LIMIT=5 instances.
module tb_stopwatch_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stopwatch_counter_if sw ();
  stopwatch_counter_if sw5 ();

  stopwatch_counter #(.MIN_LIMIT(59)) dut  (.clk(clk), .rst_n(rst_n), .bus(sw));
  stopwatch_counter #(.MIN_LIMIT(5))  dut5 (.clk(clk), .rst_n(rst_n), .bus(sw5));

  // Observed {sec_1, sec_2, min_1, min_2, blink_min, blink_sec, paused}
  logic [18:0] obs0, obs1;
  assign obs0 = {sw.sec_1, sw.sec_2, sw.min_1, sw.min_2, sw.blink_min, sw.blink_sec, sw.paused};
  assign obs1 = {sw5.sec_1, sw5.sec_2, sw5.min_1, sw5.min_2, sw5.blink_min, sw5.blink_sec, sw5.paused};

  // Reference model: time as plain minute/second integers
  int lim [2] = '{59, 5};
  int ms  [2];
  int mm  [2];
  bit m_flag, m_pe, m_pbq, m_adj, m_bm, m_bs;

  function automatic logic [18:0] dv(int m, int s, bit bm, bit bs, bit p);
    return {4'(s % 10), 4'(s / 10), 4'(m % 10), 4'(m / 10), bm, bs, p};
  endfunction

  function automatic logic [18:0] expv(int k);
    return dv(mm[k], ms[k], m_bm, m_bs, m_flag);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0;
      mm[k] = 0;
    end
    m_flag = 0; m_pe = 0; m_pbq = 0; m_adj = 0; m_bm = 0; m_bs = 0;
  endfunction

  function automatic void model_step(bit t1, bit t2, bit pb, bit c, bit a, bit s);
    int tot;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        ms[k] = 0;
        mm[k] = 0;
      end else if (m_adj && t2) begin
        if (s) ms[k] = (ms[k] + 1) % 60;
        else   mm[k] = (mm[k] == lim[k]) ? 0 : mm[k] + 1;
      end else if (!m_adj && !m_flag && t1) begin
        tot = mm[k] * 60 + ms[k] + 1;
        if (tot > lim[k] * 60 + 59) tot = 0;
        mm[k] = tot / 60;
        ms[k] = tot % 60;
      end
    end
    m_flag = m_flag ^ m_pe;
    m_pe   = pb & ~m_pbq;
    m_pbq  = pb;
    m_adj  = a;
    m_bm   = a & ~s;
    m_bs   = a & s;
  endfunction

  task automatic cyc(bit t1, bit t2, bit pb, bit c, bit a, bit s);
    sw.tick_1hz = t1;  sw.tick_2hz = t2;  sw.pause_btn = pb;
    sw.clr = c;        sw.adj = a;        sw.sel = s;
    sw5.tick_1hz = t1; sw5.tick_2hz = t2; sw5.pause_btn = pb;
    sw5.clr = c;       sw5.adj = a;       sw5.sel = s;
    @(posedge clk);
    model_step(t1, t2, pb, c, a, s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic set_time(int m, int s);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    repeat (m) begin
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 1, 1);
    repeat (s) begin
      cyc(0, 1, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
    end
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (obs0 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL reset_main got=%h want=%h", obs0, dv(0, 0, 0, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL reset_lim5 got=%h want=%h", obs1, dv(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rollover();
    do_reset();
    ticks(3599);
    n_vec++;
    if (obs0 !== dv(59, 59, 0, 0, 0)) begin
      n_err++; $display("FAIL rollover_5959 got=%h want=%h", obs0, dv(59, 59, 0, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(5, 59, 0, 0, 0)) begin
      n_err++; $display("FAIL rollover_lim5_0559 got=%h want=%h", obs1, dv(5, 59, 0, 0, 0));
    end
    cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs0 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL rollover_wrap got=%h want=%h", obs0, dv(0, 0, 0, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL rollover_lim5_wrap got=%h want=%h", obs1, dv(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_carry();
    do_reset();
    ticks(9);
    cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs0 !== dv(0, 10, 0, 0, 0)) begin
      n_err++; $display("FAIL carry_0010 got=%h want=%h", obs0, dv(0, 10, 0, 0, 0));
    end
    set_time(9, 59);
    cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs0 !== dv(10, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL carry_1000 got=%h want=%h", obs0, dv(10, 0, 0, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(4, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL carry_lim5_0400 got=%h want=%h", obs1, dv(4, 0, 0, 0, 0));
    end
    set_time(5, 59);
    cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs0 !== dv(6, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL carry_0600 got=%h want=%h", obs0, dv(6, 0, 0, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL carry_lim5_wrap got=%h want=%h", obs1, dv(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_pause();
    do_reset();
    ticks(7);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    ticks(5);
    n_vec++;
    if (obs0 !== dv(0, 7, 0, 0, 1)) begin
      n_err++; $display("FAIL pause_hold got=%h want=%h", obs0, dv(0, 7, 0, 0, 1));
    end
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    ticks(1);
    n_vec++;
    if (obs0 !== dv(0, 8, 0, 0, 0)) begin
      n_err++; $display("FAIL pause_resume got=%h want=%h", obs0, dv(0, 8, 0, 0, 0));
    end
    // Tick lands in the same cycle as the detected edge: old flag still counts it
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs0 !== dv(0, 9, 0, 0, 1)) begin
      n_err++; $display("FAIL pause_coincident_tick got=%h want=%h", obs0, dv(0, 9, 0, 0, 1));
    end
    ticks(2);
    n_vec++;
    if (obs0 !== dv(0, 9, 0, 0, 1)) begin
      n_err++; $display("FAIL pause_hold2 got=%h want=%h", obs0, dv(0, 9, 0, 0, 1));
    end
  endtask

  task automatic test_adjust();
    do_reset();
    ticks(58);
    cyc(0, 1, 0, 0, 1, 1);
    repeat (3) begin
      cyc(1, 1, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
    end
    n_vec++;
    if (obs0 !== dv(0, 1, 0, 1, 0)) begin
      n_err++; $display("FAIL adjust_sec got=%h want=%h", obs0, dv(0, 1, 0, 1, 0));
    end
    cyc(0, 0, 0, 0, 1, 0);
    repeat (2) begin
      cyc(1, 1, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
    end
    n_vec++;
    if (obs0 !== dv(2, 1, 1, 0, 0)) begin
      n_err++; $display("FAIL adjust_min got=%h want=%h", obs0, dv(2, 1, 1, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(2, 1, 1, 0, 0)) begin
      n_err++; $display("FAIL adjust_lim5 got=%h want=%h", obs1, dv(2, 1, 1, 0, 0));
    end
  endtask

  task automatic test_pause_adjust();
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    n_vec++;
    if (obs0 !== dv(2, 1, 1, 0, 1)) begin
      n_err++; $display("FAIL padj_flag got=%h want=%h", obs0, dv(2, 1, 1, 0, 1));
    end
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    n_vec++;
    if (obs0 !== dv(2, 1, 0, 0, 1)) begin
      n_err++; $display("FAIL padj_exit_paused got=%h want=%h", obs0, dv(2, 1, 0, 0, 1));
    end
  endtask

  task automatic test_clear();
    set_time(12, 34);
    n_vec++;
    if (obs0 !== dv(12, 34, 0, 0, 0)) begin
      n_err++; $display("FAIL clear_setup got=%h want=%h", obs0, dv(12, 34, 0, 0, 0));
    end
    cyc(1, 0, 0, 1, 0, 0);
    n_vec++;
    if (obs0 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL clear_over_tick got=%h want=%h", obs0, dv(0, 0, 0, 0, 0));
    end
    cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs0 !== dv(0, 1, 0, 0, 0)) begin
      n_err++; $display("FAIL clear_still_run got=%h want=%h", obs0, dv(0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ticks(20);
    cyc(0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs0 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL async_reset_main got=%h want=%h", obs0, dv(0, 0, 0, 0, 0));
    end
    n_vec++;
    if (obs1 !== dv(0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL async_reset_lim5 got=%h want=%h", obs1, dv(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit a, s, pb;
    a = 0; s = 0; pb = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) a = ~a;
      if ($urandom_range(0, 9) == 0)  s = ~s;
      if ($urandom_range(0, 5) == 0)  pb = ~pb;
      cyc(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0), pb,
          bit'($urandom_range(0, 59) == 0), a, s);
      n_vec++;
      if (obs0 !== expv(0)) begin
        n_err++; $display("FAIL random_main cyc=%0d got=%h want=%h", i, obs0, expv(0));
      end
      n_vec++;
      if (obs1 !== expv(1)) begin
        n_err++; $display("FAIL random_lim5 cyc=%0d got=%h want=%h", i, obs1, expv(1));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rollover();
    test_carry();
    test_pause();
    test_adjust();
    test_pause_adjust();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
